// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module seg_scan_ctrl #(
    parameter int unsigned N_DIG = 4,
    parameter int unsigned DIV   = 50000,
    parameter int unsigned BLANK = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     load_i,
    input  logic [4*N_DIG-1:0]       value_i,
    output logic                     pending_o,
    output logic [3:0]               digit_data_o,
    output logic [N_DIG-1:0]         an_o,
    output logic [$clog2(N_DIG)-1:0] digit_idx_o,
    output logic                     frame_start_o
);

    localparam int unsigned IdxW   = $clog2(N_DIG);
    localparam int unsigned W      = 4 * N_DIG;
    localparam int unsigned MaxCnt = (DIV > BLANK) ? DIV : BLANK;
    localparam int unsigned CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;

    typedef enum logic {StGap, StShow} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [W-1:0]     shadow_q, shadow_d;
    logic [W-1:0]     disp_q, disp_d;
    logic             pending_q, pending_d;
    logic [3:0]       digit_data_q, digit_data_d;
    logic [N_DIG-1:0] an_q, an_d;
    logic             frame_start_q, frame_start_d;

    logic [3:0] disp_nib;
    logic       lit;

    always_comb begin
        disp_nib = disp_q[3:0];
        for (int k = 0; k < int'(N_DIG); k++) begin
            if (idx_q == IdxW'(k)) disp_nib = disp_q[4*k +: 4];
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // Digit k is dark when it and every more-significant nibble are zero.
    always_comb begin
        lit = 1'b1;
        for (int k = 1; k < int'(N_DIG); k++) begin
            if (idx_q == IdxW'(k)) lit = ((disp_q >> (4 * k)) != '0);
        end
    end
`else
    assign lit = 1'b1;
`endif

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        shadow_d      = shadow_q;
        disp_d        = disp_q;
        pending_d     = pending_q;
        digit_data_d  = digit_data_q;
        an_d          = an_q;
        frame_start_d = 1'b0;

        unique case (state_q)
            StGap: begin
                if (cnt_q == CntW'(BLANK - 1)) begin
                    cnt_d        = '0;
                    state_d      = StShow;
                    an_d         = lit ? ~(N_DIG'(1) << idx_q) : '1;
                    digit_data_d = disp_nib;
                    if (idx_q == '0) begin
                        frame_start_d = 1'b1;
                        // Frame boundary: swap in the shadow word, bypassing digit 0.
                        if (pending_q) begin
                            disp_d       = shadow_q;
                            pending_d    = 1'b0;
                            digit_data_d = shadow_q[3:0];
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StShow: begin
                if (cnt_q == CntW'(DIV - 1)) begin
                    cnt_d   = '0;
                    idx_d   = (idx_q == IdxW'(N_DIG - 1)) ? '0 : idx_q + 1'b1;
                    state_d = StGap;
                    an_d    = '1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StGap;
        endcase

        // A load on the boundary cycle lands after the swap, so it stays pending.
        if (load_i) begin
            shadow_d  = value_i;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= StGap;
            cnt_q         <= '0;
            idx_q         <= '0;
            shadow_q      <= '0;
            disp_q        <= '0;
            pending_q     <= 1'b0;
            digit_data_q  <= '0;
            an_q          <= '1;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            disp_q        <= disp_d;
            pending_q     <= pending_d;
            digit_data_q  <= digit_data_d;
            an_q          <= an_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign pending_o     = pending_q;
    assign digit_data_o  = digit_data_q;
    assign an_o          = an_q;
    assign digit_idx_o   = idx_q;
    assign frame_start_o = frame_start_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl (N_DIG=4, DIV=4, BLANK=2): time-indexed model plus directed literals.
module tb_seg_scan_ctrl;

    localparam int Frame = 24;
    localparam int Slot  = 6;

    logic        clk, rst_n, load;
    logic [15:0] value;
    logic        pending, frame_start;
    logic [3:0]  digit_data, an;
    logic [1:0]  digit_idx;

    int total = 0;
    int bad   = 0;

    seg_scan_ctrl #(.N_DIG(4), .DIV(4), .BLANK(2)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .load_i       (load),
        .value_i      (value),
        .pending_o    (pending),
        .digit_data_o (digit_data),
        .an_o         (an),
        .digit_idx_o  (digit_idx),
        .frame_start_o(frame_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model state: cycles since the reset edge, load path, currently displayed word.
    bit          m_valid = 0;
    int          m_t;
    logic [15:0] m_shadow, m_disp;
    logic        m_pend;
    logic [3:0]  m_dd;

    function automatic logic [3:0] exp_an(int t, logic [15:0] d);
        int  p, s;
        bit  on;
        p  = t % Frame;
        s  = p / Slot;
        on = 1;
`ifdef LEADING_ZERO_BLANK_EN
        on = (s == 0) || ((d >> (4 * s)) != 16'h0);
`endif
        if ((p % Slot) < 2 || !on) return 4'hF;
        return ~(4'b0001 << s);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s got=%0h want=%0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid  = 1;
            m_t      = 0;
            m_shadow = '0;
            m_disp   = '0;
            m_pend   = 0;
            m_dd     = '0;
        end else if (m_valid) begin
            m_t++;
            if (m_t % Frame == 2 && m_pend) begin
                m_disp = m_shadow;
                m_pend = 0;
            end
            if (load) begin
                m_shadow = value;
                m_pend   = 1;
            end
            if (m_t % Slot == 2) m_dd = 4'((m_disp >> (4 * ((m_t % Frame) / Slot))) & 16'hF);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_an", 32'(an), 32'(exp_an(m_t, m_disp)));
            chk("model_digit_data", 32'(digit_data), 32'(m_dd));
            chk("model_digit_idx", 32'(digit_idx), 32'((m_t % Frame) / Slot));
            chk("model_frame_start", 32'(frame_start), 32'(m_t % Frame == 2));
            chk("model_pending", 32'(pending), 32'(m_pend));
        end
    end

    task automatic wait_phase(input int ph);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((m_t % Frame) != ph && n < 100);
        if ((m_t % Frame) != ph) chk("wait_phase_timeout", 32'(m_t % Frame), 32'(ph));
    endtask

    task automatic pulse_load(input logic [15:0] v);
        load  = 1'b1;
        value = v;
        @(negedge clk);
        load  = 1'b0;
    endtask

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [3:0] AnSlot2Lz = 4'hF;
    localparam logic [3:0] AnSlot3Lz = 4'hF;
    localparam logic [3:0] AnSlot1Z  = 4'hF;
`else
    localparam logic [3:0] AnSlot2Lz = 4'hB;
    localparam logic [3:0] AnSlot3Lz = 4'h7;
    localparam logic [3:0] AnSlot1Z  = 4'hD;
`endif

    logic [3:0] an_seq [Frame] = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE,
                                   4'hF, 4'hF, 4'hD, 4'hD, 4'hD, 4'hD,
                                   4'hF, 4'hF, 4'hB, 4'hB, 4'hB, 4'hB,
                                   4'hF, 4'hF, 4'h7, 4'h7, 4'h7, 4'h7};
    logic [3:0] dd_1234 [4] = '{4'h4, 4'h3, 4'h2, 4'h1};
    logic [3:0] an_one  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    initial begin
        rst_n = 1'b0;
        load  = 1'b0;
        value = '0;
        repeat (2) @(negedge clk);
        chk("rst_an", 32'(an), 32'(an_seq[0]));
        chk("rst_pending", 32'(pending), 32'd0);
        rst_n = 1'b1;
        for (int i = 1; i < 30; i++) begin
            @(negedge clk);
            chk("scan_an", 32'(an), 32'(an_seq[i % Frame]));
            chk("scan_dd", 32'(digit_data), 32'd0);
        end

        // Load mid-frame while digit 2 is shown.
        wait_phase(14);
        pulse_load(16'h1234);
        chk("load_pending", 32'(pending), 32'd1);
        chk("load_old_dd", 32'(digit_data), 32'd0);
        wait_phase(2);
        chk("bound_pending", 32'(pending), 32'd0);
        chk("bound_fs", 32'(frame_start), 32'd1);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) repeat (Slot) @(negedge clk);
            chk("w1234_dd", 32'(digit_data), 32'(dd_1234[k]));
            chk("w1234_an", 32'(an), 32'(an_one[k]));
        end

        // Two loads in one frame: last one wins.
        wait_phase(8);
        pulse_load(16'h1111);
        wait_phase(14);
        pulse_load(16'h5678);
        wait_phase(2);
        chk("last_wins_dd", 32'(digit_data), 32'h8);

        // Load on the exact boundary cycle.
        wait_phase(1);
        pulse_load(16'h9999);
        chk("edge_old_dd", 32'(digit_data), 32'h8);
        chk("edge_pending", 32'(pending), 32'd1);
        wait_phase(2);
        chk("edge_new_dd", 32'(digit_data), 32'h9);
        chk("edge_pending_clr", 32'(pending), 32'd0);

        // Reset mid-SHOW of digit 3 with a load pending.
        wait_phase(14);
        pulse_load(16'h4321);
        wait_phase(20);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_an", 32'(an), 32'hF);
        chk("mrst_dd", 32'(digit_data), 32'd0);
        chk("mrst_idx", 32'(digit_idx), 32'd0);
        chk("mrst_pending", 32'(pending), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_gap_an", 32'(an), 32'hF);
        @(negedge clk);
        chk("mrst_show_an", 32'(an), 32'hE);
        chk("mrst_show_dd", 32'(digit_data), 32'd0);

        // Leading-zero words.
        wait_phase(8);
        pulse_load(16'h0042);
        wait_phase(2);
        chk("w0042_d0", 32'(digit_data), 32'h2);
        wait_phase(8);
        chk("w0042_d1_an", 32'(an), 32'hD);
        chk("w0042_d1_dd", 32'(digit_data), 32'h4);
        wait_phase(14);
        chk("w0042_d2_an", 32'(an), 32'(AnSlot2Lz));
        wait_phase(20);
        chk("w0042_d3_an", 32'(an), 32'(AnSlot3Lz));
        pulse_load(16'h0000);
        wait_phase(2);
        chk("w0000_d0_an", 32'(an), 32'hE);
        chk("w0000_d0_dd", 32'(digit_data), 32'h0);
        wait_phase(8);
        chk("w0000_d1_an", 32'(an), 32'(AnSlot1Z));

        // Arbitrary nibbles pass through.
        wait_phase(14);
        pulse_load(16'hFA0B);
        repeat (2 * Frame) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
